// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared segment codes, conversion states and refresh timing helper
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Clocks spent on each digit per scan; never zero so the refresh counter always advances.
  function automatic int unsigned digit_period(input int unsigned clk_freq,
                                               input int unsigned refresh_hz,
                                               input int unsigned num_digits);
    int unsigned p;
    p = clk_freq / (refresh_hz * num_digits);
    if (p < 1) p = 1;
    return p;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; a nibble above 9 cannot come out of the converter, shown blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_seg_display_if.sv
// rtl/score_seg_display_if.sv - score input and seven-segment display signal bundle
interface score_seg_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [15:0]           score;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  busy;

  modport master (output score, input an, input seg, input dp, input busy);
  modport slave  (input score, output an, output seg, output dp, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 16-bit binary to 5-digit BCD converter (double dabble)
import score_display_pkg::*;

module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] din,
  output logic [19:0] bcd,
  output logic [15:0] value,
  output logic        busy,
  output logic        done
);

  conv_state_t state;
  logic [35:0] sr;
  logic [4:0]  iter;
  logic [35:0] sr_adj;

  // Add 3 to every BCD nibble that would overflow past 9 on the next shift.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 5; k++) begin
      if (sr[16 + 4*k +: 4] >= 4'd5) begin
        sr_adj[16 + 4*k +: 4] = sr[16 + 4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture, 16 adjust-and-shift steps, then publish the result in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      iter  <= '0;
      value <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {20'b0, din};
            value <= din;
            iter  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr   <= sr_adj << 1;
          iter <= iter + 5'd1;
          if (iter == 5'd15) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= sr[35:16];
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_seg_display.sv
// rtl/score_seg_display.sv - score to decimal conversion and multiplexed 8-digit display drive
import score_display_pkg::*;

module score_seg_display #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  score_seg_display_if.slave disp
);

  localparam int unsigned DIGIT_PERIOD = digit_period(CLK_FREQ, REFRESH_HZ, NUM_DIGITS);
  localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [15:0]           last_conv;
  logic                  start;
  logic [19:0]           shown;
  logic [15:0]           conv_value;
  logic                  conv_busy;
  logic                  conv_done;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4:0]            lit;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  // The converter only looks at start while idle, so mid-conversion score changes are ignored.
  assign start = (disp.score != last_conv);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (disp.score),
    .bcd   (shown),
    .value (conv_value),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // Remember the value just published, updated on the same edge that leaves DONE.
  always_ff @(posedge clk) begin
    if (reset) last_conv <= '0;
    else if (conv_done) last_conv <= conv_value;
  end

  // Refresh counter and digit index advance together on counter wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(DIGIT_PERIOD - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit k lights only if it or a more significant nibble is non-zero; digit 0 always lights.
  always_comb begin
    lit    = '0;
    lit[4] = |shown[19:16];
    lit[3] = lit[4] | (|shown[15:12]);
    lit[2] = lit[3] | (|shown[11:8]);
    lit[1] = lit[2] | (|shown[7:4]);
    lit[0] = 1'b1;
  end

  // Pick the segment pattern for the current digit; positions above the BCD field stay blank.
  always_comb begin
    seg_next = SEG_BLANK;
    for (int k = 0; k < 5; k++) begin
      if ((int'(idx) == k) && lit[k]) seg_next = seg_encode(shown[4*k +: 4]);
    end
  end

  // Registered anode and segment drive for the current digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
      seg_q <= seg_next;
    end
  end

  assign disp.an   = an_q;
  assign disp.seg  = seg_q;
  assign disp.dp   = 1'b1;
  assign disp.busy = conv_busy;

endmodule

// File: tb/tb_score_seg_display.sv
// tb/tb_score_seg_display.sv - self-checking bench for score_seg_display
module tb_score_seg_display;

  localparam int ND  = 8;
  localparam int CF  = 800;
  localparam int RH  = 10;
  localparam int PER = CF / (RH * ND);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  score_seg_display_if #(.NUM_DIGITS(ND)) disp ();

  score_seg_display #(.CLK_FREQ(CF), .REFRESH_HZ(RH), .NUM_DIGITS(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (disp)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pattern for digit k of decimal value v, from the display rules.
  function automatic logic [6:0] seg_of(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k >= 5) return 7'h7F;
    if (k > 0 && v < p) return 7'h7F;
    return seg_tab[(v / p) % 10];
  endfunction

  int m_cnt, m_idx, m_shown, m_last, m_cap, m_left;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_busy;

  // Behavioural model: outputs follow the pre-edge digit and value; a conversion publishes 17 edges after capture.
  always @(posedge clk) begin
    if (reset) begin
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_busy = 1'b0;
      m_cnt = 0; m_idx = 0; m_shown = 0; m_last = 0; m_left = 0; m_cap = 0;
    end else begin
      exp_an  = ~(8'd1 << m_idx);
      exp_seg = seg_of(m_shown, m_idx);
      if (m_cnt == PER - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
      if (m_left == 0) begin
        if (int'(disp.score) != m_last) begin
          m_cap = int'(disp.score); m_left = 17; exp_busy = 1'b1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_shown = m_cap; m_last = m_cap; exp_busy = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("an", {24'd0, disp.an}, {24'd0, exp_an});
      check("seg", {25'd0, disp.seg}, {25'd0, exp_seg});
      check("busy", {31'd0, disp.busy}, {31'd0, exp_busy});
      check("dp", {31'd0, disp.dp}, 32'd1);
    end
  end

  logic [6:0] cap [8];

  task automatic capture_scan();
    logic [7:0] pat;
    for (int k = 0; k < 8; k++) cap[k] = 7'h00;
    repeat (PER * ND + 5) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        pat = ~(8'd1 << k);
        if (disp.an == pat) cap[k] = disp.seg;
      end
    end
  endtask

  task automatic check_scan(input string name, input logic [55:0] exp);
    capture_scan();
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_d%0d", name, k), {25'd0, cap[k]}, {25'd0, exp[k*7 +: 7]});
  endtask

  task automatic busy_count(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (disp.busy) n++;
    end
  endtask

  int n;
  int streak;

  initial begin
    disp.score = 16'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_an", {24'd0, disp.an}, 32'hFE);
    check("rst_seg", {25'd0, disp.seg}, 32'h40);
    busy_count(100, n);
    check("zero_busy", n, 0);
    check_scan("zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    check("model_12345_d0", {25'd0, seg_of(12345, 0)}, 32'h12);
    check("model_65535_d4", {25'd0, seg_of(65535, 4)}, 32'h02);
    check("model_7_d1", {25'd0, seg_of(7, 1)}, 32'h7F);

    disp.score = 16'd12345;
    busy_count(40, n);
    check("busy_12345", n, 17);
    check_scan("s12345", {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});

    disp.score = 16'd65535;
    busy_count(40, n);
    check("busy_65535", n, 17);
    check_scan("s65535", {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12});

    disp.score = 16'd7;
    busy_count(40, n);
    check_scan("s7", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});

    disp.score = 16'd100;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (disp.busy) n++;
      if (i == 2) disp.score = 16'd250;
    end
    check("busy_100_250", n, 34);
    check_scan("s250", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h12, 7'h40});

    disp.score = 16'd999;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_an", {24'd0, disp.an}, 32'hFE);
    streak = 0;
    while (disp.an == 8'hFE && streak < 20) begin
      streak++;
      @(negedge clk);
    end
    check("digit_period", streak, 10);
    busy_count(40, n);
    check_scan("s999", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10, 7'h10});

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_seg_display.md
Name: score_seg_display

Overview:
- Reader-side consumer of the 16-bit game score: converts the binary score to decimal and drives the board's 8-digit, active-low, common-anode seven-segment display.
- Converts sequentially with a double-dabble FSM, then time-multiplexes the digits with a refresh counter.
- Sits beside the processor wrapper in the FPGA top and runs on the 100 MHz board clock.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- REFRESH_HZ, 1000, full-display refresh rate in Hz.
- NUM_DIGITS, 8, number of physical digits; must be at least 5.

Ports:
- clk  in  1  board clock.
- reset  in  1  synchronous, active-high reset.
- score  in  16  unsigned binary score, sampled only when the FSM is in IDLE.
- an  out  NUM_DIGITS  digit anodes, active-low, one-hot low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held at 1 at all times.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset values: an=all 1s; seg=7'h7F; dp=1; busy=0; shown BCD register=0; last-converted register=0; digit index=0; refresh counter=0; FSM=IDLE.
- FSM states:
  - IDLE: if score != last-converted, load the shift register {20'b0, score}, clear the iteration counter, set busy, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is >=5, then shift left by 1. After 16 iterations, go to DONE.
  - DONE: copy the 5 BCD nibbles into the shown register atomically, set last-converted to the captured value, clear busy, and go to IDLE.
- Latency: a change on score appears in the shown register 18 clocks later (1 capture + 16 shift + 1 done).
- Score changes during SHIFT or DONE are ignored. In the cycle after DONE, IDLE re-compares and restarts if score differs. Intermediate values are never displayed.
- Reset during a conversion aborts it. The shown register clears to 0, and the first comparison after reset triggers a conversion only if score != 0.
- Refresh timing:
  - DIGIT_PERIOD = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS), integer division, minimum 1.
  - The refresh counter counts 0..DIGIT_PERIOD-1 and wraps to 0.
  - On wrap, the digit index increments; it wraps from NUM_DIGITS-1 to 0.
- Outputs are registered from the current digit index: an = ~(1 << idx), seg = encode(digit idx).
  - In the first cycle after reset deasserts, an = ...1110 and seg = "0" (7'h40).
- Digit content:
  - idx 0-4 show BCD nibbles 0-4; idx 0 is the least significant.
  - idx >=5 are blank (7'h7F).
  - Leading zeros are blanked: digit k>0 is blank if nibbles k..4 are all zero.
  - Digit 0 always shows its value.
- Segment encoding (active-low), digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex). Nibbles >9 cannot occur; encode them as blank.
- Widths: the BCD field is 20 bits. 65535 maps to 6,5,5,3,5 with no overflow.

Decomposition:
- Package score_display_pkg holds:
  - the segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - the function computing DIGIT_PERIOD.
- Sub-module bin2bcd_seq (16-bit in, 20-bit BCD out, start/busy/done) holds the double-dabble FSM.
- Refresh, blanking, and encoding stay in the top.

Test Plan:
- Reset with score=0 -> an=FE, seg=40 on every scan; digits 1-7 stay blank; busy never rises.
- score=12345 -> busy high for 17 cycles; shown digits 0..4 = 5,4,3,2,1; scanning seg values 12, 19, 30, 24, 79, then blank.
- score=65535 -> digits 0..4 = 5,3,5,5,6; no corruption from the add-3 stage.
- score=7 -> digit 0 = 78; digits 1-7 blank (leading-zero blanking).
- score 100 -> 250 two cycles into SHIFT -> 100 is shown first; a second conversion starts the cycle after DONE; 250 is shown 18 cycles after that; no intermediate value ever appears.
- CLK_FREQ=800, REFRESH_HZ=10 -> an changes every 10 cycles in the sequence FE, FD, FB, ..., 7F, FE; reset asserted mid-scan returns to an=FE one cycle after release.
